// File: rtl/lsu_stage.sv
// Load/store stage between EXU and WBU: one instruction in flight, single-outstanding
// memory port, byte-lane steering for stores and lane extraction/extension for loads.
//
// state | meaning
// IDLE  | ready to accept an instruction from EXU
// REQ   | memory request presented, waiting for mem_req_ready
// WAIT  | request accepted, waiting for mem_resp_valid
// DONE  | result held for WBU until out_ready
module lsu_stage #(
  parameter int SIDE_W = 55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_inst,
  input  logic [31:0]       in_result,
  input  logic [31:0]       in_wdata,
  input  logic              in_mem_ren,
  input  logic              in_mem_wen,
  input  logic [2:0]        in_funct3,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_result,
  output logic [SIDE_W-1:0] out_side,
  output logic              out_mem_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [31:0]       mem_req_addr,
  output logic              mem_req_wen,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata,
  input  logic              mem_resp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  f3_q;
  logic        store_q, load_q;
  logic        accept;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  assign accept = in_valid && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (in_mem_ren || in_mem_wen) ? REQ : DONE;
      REQ:  if (mem_req_ready) state_nxt = WAIT;
      WAIT: if (mem_resp_valid) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pc      <= '0;
      out_inst    <= '0;
      out_result  <= '0;
      out_side    <= '0;
      out_mem_err <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      store_q     <= 1'b0;
      load_q      <= 1'b0;
    end else if (accept) begin
      out_pc      <= in_pc;
      out_inst    <= in_inst;
      out_result  <= in_result;
      out_side    <= in_side;
      out_mem_err <= 1'b0;
      addr_q      <= in_result;
      wdata_q     <= in_wdata;
      f3_q        <= in_funct3;
      store_q     <= in_mem_wen;
      load_q      <= in_mem_ren && !in_mem_wen;  // store wins when both are set
    end else if (state == WAIT && mem_resp_valid) begin
      out_result  <= load_q ? load_data : addr_q;
      out_mem_err <= mem_resp_err;
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_resp_rdata[7:0];
      2'd1:    byte_sel = mem_resp_rdata[15:8];
      2'd2:    byte_sel = mem_resp_rdata[23:16];
      default: byte_sel = mem_resp_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
    // funct3[1] set means word (covers 2, 3, 6, 7); funct3[2] selects zero-extend
    if (f3_q[1])      load_data = mem_resp_rdata;
    else if (f3_q[0]) load_data = {{16{half_sel[15] & ~f3_q[2]}}, half_sel};
    else              load_data = {{24{byte_sel[7] & ~f3_q[2]}}, byte_sel};
  end

  always_comb begin
    st_wdata = wdata_q;
    st_wstrb = 4'b1111;
    if (!f3_q[1]) begin
      if (f3_q[0]) begin
        st_wdata = {2{wdata_q[15:0]}};
        st_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      end else begin
        st_wdata = {4{wdata_q[7:0]}};
        st_wstrb = 4'b0001 << addr_q[1:0];
      end
    end
  end

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = store_q;
  assign mem_req_wdata = st_wdata;
  assign mem_req_wstrb = store_q ? st_wstrb : 4'b0000;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: ALU passthrough, load extension, store lane steering,
// memory/WBU backpressure and reset in the middle of a transaction.
module tb_lsu_stage;
  localparam int SIDE_W = 55;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [31:0]       in_pc, in_inst, in_result, in_wdata;
  logic              in_mem_ren, in_mem_wen;
  logic [2:0]        in_funct3;
  logic [SIDE_W-1:0] in_side;
  logic              out_valid, out_ready;
  logic [31:0]       out_pc, out_inst, out_result;
  logic [SIDE_W-1:0] out_side;
  logic              out_mem_err;
  logic              mem_req_valid, mem_req_ready;
  logic [31:0]       mem_req_addr;
  logic              mem_req_wen;
  logic [31:0]       mem_req_wdata;
  logic [3:0]        mem_req_wstrb;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_rdata;
  logic              mem_resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_stage #(.SIDE_W(SIDE_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_result(in_result), .in_wdata(in_wdata),
    .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen), .in_funct3(in_funct3),
    .in_side(in_side),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_result(out_result),
    .out_side(out_side), .out_mem_err(out_mem_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_err(mem_resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one instruction for a single cycle; caller must be in IDLE
  task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic [31:0] wd,
                       input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [SIDE_W-1:0] side);
    in_pc      = pc;
    in_inst    = pc ^ 32'h0000_0013;
    in_result  = res;
    in_wdata   = wd;
    in_mem_ren = ren;
    in_mem_wen = wen;
    in_funct3  = f3;
    in_side    = side;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    in_result  = 32'hDEAD_0000;
    in_wdata   = 32'hDEAD_0001;
  endtask

  task automatic alu_op(input string tag, input logic [31:0] res, input logic [SIDE_W-1:0] side);
    out_ready = 1'b1;
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    issue(32'h8000_0100, res, 32'h0, 1'b0, 1'b0, 3'd2, side);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_result"}, {32'd0, out_result}, {32'd0, res});
    check({tag, "_side"}, {9'd0, out_side}, {9'd0, side});
    check({tag, "_pc"}, {32'd0, out_pc}, 64'h8000_0100);
    check({tag, "_no_req"}, {63'd0, mem_req_valid}, 64'd0);
    tick();
    check({tag, "_drain"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  task automatic mem_op(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                        input logic ren, input logic wen, input logic [2:0] f3,
                        input int req_dly, input int resp_dly, input int done_hold,
                        input logic [31:0] rdata, input logic err,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_res);
    logic [SIDE_W-1:0] side;
    side = {23'h5A5A5A, addr};
    mem_req_ready = (req_dly == 0);
    out_ready     = (done_hold == 0);
    issue(32'h8000_0200, addr, wd, ren, wen, f3, side);
    for (int i = 0; i <= req_dly; i++) begin
      if (i == req_dly) mem_req_ready = 1'b1;
      check({tag, "_req_valid"}, {63'd0, mem_req_valid}, 64'd1);
      check({tag, "_req_addr"}, {32'd0, mem_req_addr}, {32'd0, addr});
      check({tag, "_req_wen"}, {63'd0, mem_req_wen}, {63'd0, wen});
      check({tag, "_req_wstrb"}, {60'd0, mem_req_wstrb}, {60'd0, exp_strb});
      if (wen) check({tag, "_req_wdata"}, {32'd0, mem_req_wdata}, {32'd0, exp_wdata});
      check({tag, "_busy_req"}, {63'd0, in_ready}, 64'd0);
      tick();
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i < resp_dly; i++) begin
      check({tag, "_wait"}, {61'd0, mem_req_valid, out_valid, in_ready}, 64'd0);
      tick();
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    mem_resp_err   = err;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0BAD_0BAD;
    mem_resp_err   = 1'b0;
    for (int i = 0; i <= done_hold; i++) begin
      if (i == done_hold) out_ready = 1'b1;
      check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_result"}, {32'd0, out_result}, {32'd0, exp_res});
      check({tag, "_err"}, {63'd0, out_mem_err}, {63'd0, err});
      check({tag, "_side"}, {9'd0, out_side}, {9'd0, side});
      check({tag, "_busy_done"}, {63'd0, in_ready}, 64'd0);
      tick();
    end
    check({tag, "_drain"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_pc = '0; in_inst = '0; in_result = '0; in_wdata = '0;
    in_mem_ren = 1'b0; in_mem_wen = 1'b0; in_funct3 = '0; in_side = '0;
    out_ready = 1'b1; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_rdata = '0; mem_resp_err = 1'b0;
    #22;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_result", {32'd0, out_result}, 64'd0);
    rst = 1'b0;
    tick();

    alu_op("alu", 32'h0000_1234, 55'h12_3456_789A_BCDE);

    //       tag      addr          wdata         ren  wen  f3  rq rs dh rdata         err  strb     wdata         result
    mem_op("lb",   32'h8000_0003, 32'h0,       1, 0, 3'd0, 0, 0, 0, 32'h80FF_1234, 0, 4'b0000, 32'h0,       32'hFFFF_FF80);
    mem_op("lbu",  32'h8000_0003, 32'h0,       1, 0, 3'd4, 0, 0, 0, 32'h80FF_1234, 0, 4'b0000, 32'h0,       32'h0000_0080);
    mem_op("lb1",  32'h8000_0001, 32'h0,       1, 0, 3'd0, 0, 1, 0, 32'h80FF_1234, 0, 4'b0000, 32'h0,       32'h0000_0012);
    mem_op("lh",   32'h8000_0002, 32'h0,       1, 0, 3'd1, 0, 0, 0, 32'h80FF_1234, 0, 4'b0000, 32'h0,       32'hFFFF_80FF);
    mem_op("lhu",  32'h8000_0003, 32'h0,       1, 0, 3'd5, 0, 0, 0, 32'h80FF_1234, 0, 4'b0000, 32'h0,       32'h0000_80FF);
    mem_op("lh0",  32'h8000_0000, 32'h0,       1, 0, 3'd1, 0, 0, 0, 32'h80FF_9234, 0, 4'b0000, 32'h0,       32'hFFFF_9234);
    mem_op("sh",   32'h8000_0002, 32'h0000_ABCD, 0, 1, 3'd1, 0, 0, 0, 32'h0,     0, 4'b1100, 32'hABCD_ABCD, 32'h8000_0002);
    mem_op("sb",   32'h8000_0001, 32'h1234_56A5, 0, 1, 3'd0, 0, 0, 0, 32'h0,     0, 4'b0010, 32'hA5A5_A5A5, 32'h8000_0001);
    mem_op("sw",   32'h8000_0000, 32'hDEAD_BEEF, 0, 1, 3'd2, 0, 0, 0, 32'h0,     0, 4'b1111, 32'hDEAD_BEEF, 32'h8000_0000);
    mem_op("sw3",  32'h8000_0004, 32'hCAFE_F00D, 0, 1, 3'd3, 0, 0, 0, 32'h0,     0, 4'b1111, 32'hCAFE_F00D, 32'h8000_0004);
    mem_op("both", 32'h8000_0002, 32'h0000_0011, 1, 1, 3'd0, 0, 0, 0, 32'hFFFF_FFFF, 0, 4'b0100, 32'h1111_1111, 32'h8000_0002);
    mem_op("stall",32'h8000_0010, 32'h0,       1, 0, 3'd2, 5, 3, 0, 32'h0123_4567, 0, 4'b0000, 32'h0,       32'h0123_4567);
    mem_op("lwerr",32'h8000_0020, 32'h0,       1, 0, 3'd2, 0, 0, 4, 32'h7654_3210, 1, 4'b0000, 32'h0,       32'h7654_3210);

    // reset while waiting for a response, then a stale response arrives
    mem_req_ready = 1'b1;
    issue(32'h8000_0300, 32'h8000_0040, 32'h0, 1'b1, 1'b0, 3'd2, '0);
    tick();
    mem_req_ready = 1'b0;
    check("mid_wait", {62'd0, mem_req_valid, out_valid}, 64'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_idle", {61'd0, in_ready, out_valid, mem_req_valid}, 64'd4);
    tick();
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hFFFF_FFFF;
    tick();
    mem_resp_valid = 1'b0;
    check("stale_resp", {61'd0, in_ready, out_valid, mem_req_valid}, 64'd4);
    alu_op("post_rst", 32'h0000_5555, 55'h00_0000_0000_00AA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
